// File: rtl/stopwatch_if.sv
// Button inputs and display-side outputs of the stopwatch control stage.
// master = button/display side, slave = stopwatch_ctrl.
interface stopwatch_if;
  logic        btn_ss_n;
  logic        btn_lap_n;
  logic [15:0] bcd_out;
  logic        running;
  logic        lap_held;
  logic        overflow;

  modport master (
    output btn_ss_n, btn_lap_n,
    input  bcd_out, running, lap_held, overflow
  );

  modport slave (
    input  btn_ss_n, btn_lap_n,
    output bcd_out, running, lap_held, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, start/stop/lap FSM, tick prescaler and 4-digit BCD count.
// Optional macro SW_SATURATE_EN: count saturates at 9999 and forces STOP instead of wrapping.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic      clock,
  input  logic      reset,
  stopwatch_if.slave sw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Returns {carry_out, incremented value}; a digit at 9 (or above) wraps and carries.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (v[d*4 +: 4] >= 4'd9) begin
          r[d*4 +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[d*4 +: 4] = v[d*4 +: 4];
      end
    end
    return {c, r};
  endfunction

  // Index 0 = start/stop, index 1 = lap/clear.
  logic [1:0]    sync1_r, sync2_r, deb_r, press_r;
  logic [DW-1:0] deb_cnt_r [2];

  logic [1:0]    state_r, state_n;
  logic          lap_held_r, lap_held_n;
  logic [15:0]   lap_reg_r, lap_reg_n;
  logic [15:0]   count_r, count_n;
  logic [PW-1:0] presc_r, presc_n;
  logic          ovf_r, ovf_n;
  logic          sat_s;
  logic [16:0]   inc_s;
  logic [15:0]   bcd_r;
  logic          running_r;

  logic ss_p_s, lap_p_s;
  assign ss_p_s  = press_r[0];
  assign lap_p_s = press_r[1];

  // Synchronize both buttons and accept a level only after DEB_CYCLES stable samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r      <= 2'b11;
      sync2_r      <= 2'b11;
      deb_r        <= 2'b11;
      press_r      <= 2'b00;
      deb_cnt_r[0] <= {DW{1'b0}};
      deb_cnt_r[1] <= {DW{1'b0}};
    end else begin
      sync1_r <= {sw.btn_lap_n, sw.btn_ss_n};
      sync2_r <= sync1_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DW'(DEB_CYCLES - 1)) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= {DW{1'b0}};
            press_r[i]   <= ~sync2_r[i];
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
            press_r[i]   <= 1'b0;
          end
        end else begin
          deb_cnt_r[i] <= {DW{1'b0}};
          press_r[i]   <= 1'b0;
        end
      end
    end
  end

  // Next-state logic: the tick increment is applied before any state change in the same cycle.
  always_comb begin
    state_n    = state_r;
    lap_held_n = lap_held_r;
    lap_reg_n  = lap_reg_r;
    count_n    = count_r;
    presc_n    = presc_r;
    ovf_n      = ovf_r;
    sat_s      = 1'b0;
    inc_s      = bcd_inc(count_r);
    case (state_r)
      ST_IDLE: begin
        if (ss_p_s) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (presc_r == PW'(TICK_DIV - 1)) begin
          presc_n = {PW{1'b0}};
          ovf_n   = ovf_r | inc_s[16];
`ifdef SW_SATURATE_EN
          if (inc_s[16]) begin
            count_n = count_r;
            sat_s   = 1'b1;
          end else begin
            count_n = inc_s[15:0];
          end
`else
          count_n = inc_s[15:0];
`endif
        end else begin
          presc_n = presc_r + PW'(1);
        end
        // Lap capture uses count_r, i.e. the pre-increment value.
        if (ss_p_s || sat_s) begin
          state_n = ST_STOP;
        end else if (lap_p_s) begin
          lap_held_n = ~lap_held_r;
          if (!lap_held_r) begin
            lap_reg_n = count_r;
          end else begin
            lap_reg_n = lap_reg_r;
          end
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_STOP: begin
        if (ss_p_s) begin
          state_n = ST_RUN;
        end else if (lap_p_s) begin
          if (lap_held_r) begin
            lap_held_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
            count_n = 16'h0000;
            presc_n = {PW{1'b0}};
            ovf_n   = 1'b0;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n    = ST_IDLE;
        lap_held_n = 1'b0;
        count_n    = 16'h0000;
        presc_n    = {PW{1'b0}};
        ovf_n      = 1'b0;
      end
    endcase
  end

  // State and output registers; outputs are loaded from next-state values so they track with no lag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      lap_held_r <= 1'b0;
      lap_reg_r  <= 16'h0000;
      count_r    <= 16'h0000;
      presc_r    <= {PW{1'b0}};
      ovf_r      <= 1'b0;
      bcd_r      <= 16'h0000;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      lap_held_r <= lap_held_n;
      lap_reg_r  <= lap_reg_n;
      count_r    <= count_n;
      presc_r    <= presc_n;
      ovf_r      <= ovf_n;
      bcd_r      <= lap_held_n ? lap_reg_n : count_n;
      running_r  <= (state_n == ST_RUN);
    end
  end

  assign sw.bcd_out  = bcd_r;
  assign sw.running  = running_r;
  assign sw.lap_held = lap_held_r;
  assign sw.overflow = ovf_r;

endmodule
